// File: rtl/mem_stage_sram_ctrl_if.sv
// Signals between the MEM stage, the data-memory controller and the 16-bit SRAM pads.
// The master side is the pipeline plus the SRAM pads. The slave side is the controller.
interface mem_stage_sram_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller. Each 32-bit load or store becomes two 16-bit SRAM transfers.
//
// state | meaning
// IDLE  | no access pending; accepts a new request
// LO    | transfer of half-word [15:0], WAIT_CYCLES cycles long
// HI    | transfer of half-word [31:16], WAIT_CYCLES cycles long
// DONE  | one cycle with ready=1; the pipeline advances at the edge that ends it
module mem_stage_sram_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_stage_sram_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        op_write;
    logic [16:0] word_idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [16:0] eff_word;
    logic        phase_end;
    logic        request;

    // Address bits above 18 are dropped, so high addresses alias onto the 256K half-word array.
    assign eff_word  = 17'((bus.address - BASE) >> 2);
    assign phase_end = (cnt == CNT_LAST);
    assign request   = bus.rd_en | bus.wr_en;

    assign bus.read_data = rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_write <= 1'b0;
            word_idx <= 17'd0;
            wdata    <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            if (state == S_IDLE && request) begin
                op_write <= bus.wr_en;
                word_idx <= eff_word;
                if (bus.wr_en) begin
                    wdata <= bus.write_data;
                end
            end
            if (state == S_LO && phase_end && !op_write) begin
                rdata[15:0] <= bus.sram_dq_in;
            end
            if (state == S_HI && phase_end && !op_write) begin
                rdata[31:16] <= bus.sram_dq_in;
            end
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bus.ready       = 1'b0;
        bus.sram_addr   = 18'd0;
        bus.sram_dq_out = 16'd0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_ce_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        bus.sram_we_n   = 1'b1;
        bus.sram_ub_n   = 1'b1;
        bus.sram_lb_n   = 1'b1;

        case (state)
            S_IDLE: begin
                bus.ready = ~request;
                if (request) begin
                    state_next = S_LO;
                    cnt_next   = 4'd0;
                end
            end
            S_LO, S_HI: begin
                bus.sram_ce_n  = 1'b0;
                bus.sram_ub_n  = 1'b0;
                bus.sram_lb_n  = 1'b0;
                bus.sram_oe_n  = op_write;
                bus.sram_dq_oe = op_write;
                // During a write, we_n goes high for the last cycle so address and data are held past the strobe.
                bus.sram_we_n  = ~op_write | phase_end;
                if (state == S_LO) begin
                    bus.sram_addr = {word_idx, 1'b0};
                    if (op_write) begin
                        bus.sram_dq_out = wdata[15:0];
                    end
                end else begin
                    bus.sram_addr = {word_idx, 1'b1};
                    if (op_write) begin
                        bus.sram_dq_out = wdata[31:16];
                    end
                end
                if (phase_end) begin
                    state_next = (state == S_LO) ? S_HI : S_DONE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            S_DONE: begin
                bus.ready  = 1'b1;
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Data-memory controller of the MEM stage: turns the single-cycle word read/write request from the EX/MEM register into a multi-cycle access on the board's 16-bit external SRAM (two half-word transfers per 32-bit word). It drives `ready`, which the hazard/freeze logic inverts into the pipeline `freeze` consumed by the MEM/WB register. Read data (`read_data`) feeds that register's `MEM_read_value_in`.

## Interface
- `BASE_ADDR`, 1024: byte address of data-memory word 0; subtracted from `address`.
- `WAIT_CYCLES`, 2: clock cycles per 16-bit SRAM transfer; legal range 2..15.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rd_en` in 1: load request (MEM_R_EN from EX/MEM).
- `wr_en` in 1: store request (MEM_W_EN from EX/MEM).
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data.
- `read_data` out 32: loaded word, valid while `ready`=1 in DONE and held until the next read completes.
- `ready` out 1: 1 = no access pending or access finishing this cycle; upstream freeze = ~ready.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data to pad; `sram_dq_oe` out 1: pad drive enable.
- `sram_dq_in` in 16: read data from pad.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM strobes, active-low.

## Operation
- States: IDLE, LO, HI, DONE; 4-bit phase counter `cnt`.
- IDLE: if `wr_en` -> latch write op, address, data; go LO, cnt=0. Else if `rd_en` -> latch read op, address; go LO. `wr_en` has priority when both asserted.
- Effective address: eff = address − BASE_ADDR (32-bit wrap). Word index = eff[18:2]; eff[1:0] ignored; bits above 18 ignored (aliasing, no error).
- LO: sram_addr = {eff[18:2],1'b0}; HI: sram_addr = {eff[18:2],1'b1}. LO carries bits [15:0], HI bits [31:16].
- Each of LO/HI lasts WAIT_CYCLES cycles; cnt counts 0..WAIT_CYCLES−1, clears on phase change. LO -> HI and HI -> DONE when cnt = WAIT_CYCLES−1.
- Read: ce_n=0, oe_n=0, we_n=1, ub_n=lb_n=0, dq_oe=0. `sram_dq_in` captured at the edge ending the last LO cycle into read_data[15:0], last HI cycle into read_data[31:16].
- Write: ce_n=0, oe_n=1, ub_n=lb_n=0, dq_oe=1, dq_out = latched half. we_n=0 for cnt < WAIT_CYCLES−1, we_n=1 on the last cycle of the phase (address/data hold).
- DONE: one cycle, strobes inactive, ready=1; -> IDLE unconditionally.
- IDLE/DONE outputs: ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0.
- ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en); combinational.
- Requests are not re-sampled during LO/HI; deassertion mid-access (flush) does not abort — access completes, DONE still occurs.

## Timing
- Request visible in cycle 0 (IDLE): ready=0 in cycle 0. LO cycles 1..W, HI cycles W+1..2W, DONE cycle 2W+1 (ready=1). W=WAIT_CYCLES. Freeze length 2W+1 cycles (5 at default).
- Pipeline advances at the edge ending DONE; a new request present in the following IDLE cycle starts immediately (no dead cycle beyond DONE).
- read_data updates only at the two capture edges of a read; stable through DONE and after.
- Reset (rst_n=0 at an edge), any state incl. mid-access: state=IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_out=0, dq_oe=0, all strobes 1. Partial write is abandoned; ready reflects requests from next cycle.

## Test plan
- Reset: rst_n=0 two cycles during a HI write -> next cycle all strobes 1, dq_oe=0, read_data=0, state IDLE.
- Store: wr_en=1, address=1032, write_data=0xDEADBEEF, W=2 -> ready=0 cycles 0..4; cycles 1–2 sram_addr=4, dq_out=0xBEEF, we_n=0 cycle 1 only; cycles 3–4 sram_addr=5, dq_out=0xDEAD; ready=1 cycle 5.
- Load: SRAM model holds 0xBEEF@4, 0xDEAD@5; rd_en=1, address=1032 -> oe_n=0 cycles 1–4, read_data=0xDEADBEEF in DONE (cycle 5), held after.
- Back-to-back: load then store in consecutive instructions -> second access's LO starts exactly one cycle after first DONE; no strobe overlap.
- Both rd_en and wr_en=1, address=1024 -> write performed to sram_addr 0/1, no oe_n assertion.
- Abort-free: rd_en dropped in cycle 2 -> access still completes, DONE in cycle 5, read_data updated; W=3 variant -> DONE in cycle 7.
